// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand sequencer: states, key codes
// and datapath widths.
package calc_pkg;

  localparam int ancho_bcd = 16;
  localparam int ancho_bin = 14;
  localparam int ancho_res = 15;

  localparam logic [3:0] TECLA_SUMA   = 4'hA;
  localparam logic [3:0] TECLA_IGUAL  = 4'hB;
  localparam logic [3:0] TECLA_BORRAR = 4'hC;

  typedef enum logic [2:0] {
    ENT_A  = 3'd0,
    ENT_B  = 3'd1,
    CONV_A = 3'd2,
    CONV_B = 3'd3,
    SUMA   = 3'd4,
    RESULT = 3'd5
  } estado_t;

  function automatic logic es_digito(input logic [3:0] codigo);
    return codigo <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_entrada_operando.sv
// One 4-digit BCD operand: shift-in register with a saturating digit count.
// clr_i and en_i together restart the operand with the incoming digit.
module calc_entrada_operando (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [3:0]  digito_i,
  output logic [15:0] operando_o
);

  logic [15:0] operando_q, operando_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    operando_d = operando_q;
    cnt_d      = cnt_q;
    if (clr_i) begin
      operando_d = en_i ? {12'h000, digito_i} : 16'h0000;
      cnt_d      = en_i ? 3'd1 : 3'd0;
    end else if (en_i && (cnt_q < 3'd4)) begin
      operando_d = {operando_q[11:0], digito_i};
      cnt_d      = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      operando_q <= 16'h0000;
      cnt_q      <= 3'd0;
    end else begin
      operando_q <= operando_d;
      cnt_q      <= cnt_d;
    end
  end

  assign operando_o = operando_q;

endmodule

// File: rtl/calc_secuenciador_bcd.sv
// Operand entry and conversion sequencer: collects A and B, runs both through
// the one shared BCD-to-binary converter, then adds the binary values.
module calc_secuenciador_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  output logic [15:0] conv_bcd,
  input  logic [13:0] conv_bin,
  output logic [15:0] display_bcd,
  output logic        ocupado,
  output logic [14:0] resultado,
  output logic        resultado_valido,
  output logic [2:0]  estado_dbg
);
  import calc_pkg::*;

  // tecla_valida is a one-cycle strobe with no back-pressure: a key that
  // arrives while ocupado is high is lost unless it is TECLA_BORRAR.
  estado_t     estado_q, estado_d;
  logic [13:0] bin_a_q, bin_a_d;
  logic [13:0] bin_b_q, bin_b_d;
  logic [14:0] resultado_q, resultado_d;
  logic        valido_q, valido_d;
  logic        en_a, clr_a, en_b, clr_b;
  logic [15:0] op_a, op_b;
  logic        borrar, digito;

  assign borrar = tecla_valida && (tecla == TECLA_BORRAR);
  assign digito = tecla_valida && es_digito(tecla);

  calc_entrada_operando u_op_a (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en_a),
    .clr_i      (clr_a),
    .digito_i   (tecla),
    .operando_o (op_a)
  );

  calc_entrada_operando u_op_b (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en_b),
    .clr_i      (clr_b),
    .digito_i   (tecla),
    .operando_o (op_b)
  );

  always_comb begin
    estado_d    = estado_q;
    bin_a_d     = bin_a_q;
    bin_b_d     = bin_b_q;
    resultado_d = resultado_q;
    valido_d    = valido_q;
    en_a        = 1'b0;
    clr_a       = 1'b0;
    en_b        = 1'b0;
    clr_b       = 1'b0;
    if (borrar) begin
      estado_d    = ENT_A;
      clr_a       = 1'b1;
      clr_b       = 1'b1;
      bin_a_d     = 14'd0;
      bin_b_d     = 14'd0;
      resultado_d = 15'd0;
      valido_d    = 1'b0;
    end else begin
      case (estado_q)
        ENT_A: begin
          en_a = digito;
          if (tecla_valida && (tecla == TECLA_SUMA)) begin
            estado_d = ENT_B;
            clr_b    = 1'b1;
          end
        end
        ENT_B: begin
          en_b = digito;
          if (tecla_valida && (tecla == TECLA_IGUAL)) estado_d = CONV_A;
        end
        CONV_A: begin
          bin_a_d  = conv_bin;
          estado_d = CONV_B;
        end
        CONV_B: begin
          bin_b_d  = conv_bin;
          estado_d = SUMA;
        end
        SUMA: begin
          resultado_d = {1'b0, bin_a_q} + {1'b0, bin_b_q};
          valido_d    = 1'b1;
          estado_d    = RESULT;
        end
        RESULT: begin
          // A digit starts a fresh calculation with that digit as A.
          if (digito) begin
            clr_a    = 1'b1;
            en_a     = 1'b1;
            clr_b    = 1'b1;
            valido_d = 1'b0;
            estado_d = ENT_A;
          end
        end
        default: estado_d = ENT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= ENT_A;
      bin_a_q     <= 14'd0;
      bin_b_q     <= 14'd0;
      resultado_q <= 15'd0;
      valido_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      bin_a_q     <= bin_a_d;
      bin_b_q     <= bin_b_d;
      resultado_q <= resultado_d;
      valido_q    <= valido_d;
    end
  end

  // Both mux inputs and the select are registers, so conv_bcd is steady
  // for the whole CONV_A / CONV_B cycle.
  assign conv_bcd         = (estado_q == CONV_B) ? op_b : op_a;
  assign display_bcd      = (estado_q == ENT_A) ? op_a : op_b;
  assign ocupado          = (estado_q == CONV_A) || (estado_q == CONV_B) ||
                            (estado_q == SUMA);
  assign resultado        = resultado_q;
  assign resultado_valido = valido_q;
  assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_calc_secuenciador_bcd.sv
// Directed bench for calc_secuenciador_bcd with a behavioural model of the
// external BCD-to-binary converter.
module tb_calc_secuenciador_bcd;
  import calc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic [15:0] conv_bcd;
  logic [13:0] conv_bin;
  logic [15:0] display_bcd;
  logic        ocupado;
  logic [14:0] resultado;
  logic        resultado_valido;
  logic [2:0]  estado_dbg;

  int checks   = 0;
  int failures = 0;

  calc_secuenciador_bcd dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tecla_valida     (tecla_valida),
    .tecla            (tecla),
    .conv_bcd         (conv_bcd),
    .conv_bin         (conv_bin),
    .display_bcd      (display_bcd),
    .ocupado          (ocupado),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .estado_dbg       (estado_dbg)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- external converter model ----
  function automatic logic [13:0] bcd_a_bin(input logic [15:0] b);
    int v;
    v = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    return v[13:0];
  endfunction

  always_comb conv_bin = bcd_a_bin(conv_bcd);

  // ---- driver: called at a falling edge, returns at the next falling edge ----
  task automatic press(input logic [3:0] k);
    tecla_valida = 1'b1;
    tecla        = k;
    @(negedge clk);
    tecla_valida = 1'b0;
    tecla        = 4'h0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    tecla_valida = 1'b1;
    tecla        = 4'd5;
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    tecla_valida = 1'b0;
    tecla        = 4'h0;
    checks++;
    if (estado_dbg !== 3'(ENT_A)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", estado_dbg, 0); end
    checks++;
    if (display_bcd !== 16'h0000) begin failures++; $display("FAIL reset_display got=%h exp=0000", display_bcd); end
    checks++;
    if (conv_bcd !== 16'h0000) begin failures++; $display("FAIL reset_conv got=%h exp=0000", conv_bcd); end
    checks++;
    if ({ocupado, resultado_valido, resultado} !== 17'd0) begin
      failures++; $display("FAIL reset_outs got ocupado=%b valido=%b res=%0d exp all 0", ocupado, resultado_valido, resultado);
    end
  endtask

  task automatic test_suma_basica();
    logic [3:0] ks [10];
    ks = '{4'd1, 4'd2, 4'd3, 4'd4, TECLA_SUMA, 4'd5, 4'd6, 4'd7, 4'd8, TECLA_IGUAL};
    for (int i = 0; i < 4; i++) press(ks[i]);
    checks++;
    if (display_bcd !== 16'h1234) begin failures++; $display("FAIL basic_disp_a got=%h exp=1234", display_bcd); end
    press(ks[4]);
    checks++;
    if (estado_dbg !== 3'(ENT_B) || display_bcd !== 16'h0000) begin
      failures++; $display("FAIL basic_plus got state=%0d disp=%h exp state=1 disp=0000", estado_dbg, display_bcd);
    end
    for (int i = 5; i < 9; i++) press(ks[i]);
    checks++;
    if (display_bcd !== 16'h5678) begin failures++; $display("FAIL basic_disp_b got=%h exp=5678", display_bcd); end
    press(ks[9]);
    checks++;
    if (estado_dbg !== 3'(CONV_A) || conv_bcd !== 16'h1234 || ocupado !== 1'b1) begin
      failures++; $display("FAIL basic_conv_a got state=%0d conv=%h ocup=%b exp state=2 conv=1234 ocup=1", estado_dbg, conv_bcd, ocupado);
    end
    checks++;
    if (resultado_valido !== 1'b0) begin failures++; $display("FAIL basic_valid_t0 got=%b exp=0", resultado_valido); end
    @(negedge clk);
    checks++;
    if (estado_dbg !== 3'(CONV_B) || conv_bcd !== 16'h5678 || resultado_valido !== 1'b0) begin
      failures++; $display("FAIL basic_conv_b got state=%0d conv=%h valid=%b exp state=3 conv=5678 valid=0", estado_dbg, conv_bcd, resultado_valido);
    end
    @(negedge clk);
    checks++;
    if (estado_dbg !== 3'(SUMA) || ocupado !== 1'b1 || resultado_valido !== 1'b0) begin
      failures++; $display("FAIL basic_suma got state=%0d ocup=%b valid=%b exp state=4 ocup=1 valid=0", estado_dbg, ocupado, resultado_valido);
    end
    @(negedge clk);
    checks++;
    if (resultado_valido !== 1'b1 || resultado !== 15'd6912 || ocupado !== 1'b0) begin
      failures++; $display("FAIL basic_result got valid=%b res=%0d ocup=%b exp valid=1 res=6912 ocup=0", resultado_valido, resultado, ocupado);
    end
    @(negedge clk);
    checks++;
    if (resultado_valido !== 1'b1 || estado_dbg !== 3'(RESULT)) begin
      failures++; $display("FAIL basic_hold got valid=%b state=%0d exp valid=1 state=5", resultado_valido, estado_dbg);
    end
  endtask

  task automatic test_maximo();
    press(TECLA_BORRAR);
    for (int i = 0; i < 4; i++) press(4'd9);
    press(TECLA_SUMA);
    for (int i = 0; i < 4; i++) press(4'd9);
    press(TECLA_IGUAL);
    repeat (3) @(negedge clk);
    checks++;
    if (resultado_valido !== 1'b1 || resultado !== 15'd19998) begin
      failures++; $display("FAIL max_result got valid=%b res=%0d exp valid=1 res=19998", resultado_valido, resultado);
    end
    press(TECLA_BORRAR);
    for (int i = 1; i <= 5; i++) press(4'(i));
    checks++;
    if (display_bcd !== 16'h1234) begin failures++; $display("FAIL fifth_digit got=%h exp=1234", display_bcd); end
  endtask

  task automatic test_b_cero();
    press(TECLA_BORRAR);
    press(4'd7);
    press(TECLA_IGUAL);
    checks++;
    if (estado_dbg !== 3'(ENT_A) || ocupado !== 1'b0 || display_bcd !== 16'h0007) begin
      failures++; $display("FAIL eq_in_ent_a got state=%0d ocup=%b disp=%h exp state=0 ocup=0 disp=0007", estado_dbg, ocupado, display_bcd);
    end
    press(TECLA_SUMA);
    press(TECLA_IGUAL);
    repeat (3) @(negedge clk);
    checks++;
    if (resultado_valido !== 1'b1 || resultado !== 15'd7) begin
      failures++; $display("FAIL b_zero got valid=%b res=%0d exp valid=1 res=7", resultado_valido, resultado);
    end
  endtask

  task automatic test_ocupado_ignora();
    press(TECLA_BORRAR);
    press(4'd4);
    press(TECLA_SUMA);
    press(4'd5);
    press(TECLA_IGUAL);
    press(4'd3);
    repeat (2) @(negedge clk);
    checks++;
    if (resultado !== 15'd9 || display_bcd !== 16'h0005 || resultado_valido !== 1'b1) begin
      failures++; $display("FAIL busy_drop got res=%0d disp=%h valid=%b exp res=9 disp=0005 valid=1", resultado, display_bcd, resultado_valido);
    end
  endtask

  task automatic test_resultado_digito();
    press(4'd2);
    checks++;
    if (resultado_valido !== 1'b0 || display_bcd !== 16'h0002 || estado_dbg !== 3'(ENT_A)) begin
      failures++; $display("FAIL result_digit got valid=%b disp=%h state=%0d exp valid=0 disp=0002 state=0", resultado_valido, display_bcd, estado_dbg);
    end
    press(4'd3);
    checks++;
    if (display_bcd !== 16'h0023) begin failures++; $display("FAIL result_digit_cnt got=%h exp=0023", display_bcd); end
  endtask

  task automatic test_borrar_suma();
    press(TECLA_SUMA);
    press(4'd5);
    press(TECLA_IGUAL);
    repeat (2) @(negedge clk);
    press(TECLA_BORRAR);
    checks++;
    if (estado_dbg !== 3'(ENT_A) || ocupado !== 1'b0 || resultado_valido !== 1'b0) begin
      failures++; $display("FAIL clear_in_suma got state=%0d ocup=%b valid=%b exp state=0 ocup=0 valid=0", estado_dbg, ocupado, resultado_valido);
    end
    checks++;
    if (resultado !== 15'd0 || display_bcd !== 16'h0000 || conv_bcd !== 16'h0000) begin
      failures++; $display("FAIL clear_regs got res=%0d disp=%h conv=%h exp all 0", resultado, display_bcd, conv_bcd);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (resultado !== 15'd0 || resultado_valido !== 1'b0) begin
      failures++; $display("FAIL clear_no_sum got res=%0d valid=%b exp res=0 valid=0", resultado, resultado_valido);
    end
    press(4'd1);
    checks++;
    if (display_bcd !== 16'h0001) begin failures++; $display("FAIL clear_then_digit got=%h exp=0001", display_bcd); end
  endtask

  task automatic test_reset_mid();
    press(4'd2);
    rst_n        = 1'b0;
    tecla_valida = 1'b1;
    tecla        = 4'd3;
    @(negedge clk);
    rst_n        = 1'b1;
    tecla_valida = 1'b0;
    tecla        = 4'h0;
    checks++;
    if (display_bcd !== 16'h0000 || conv_bcd !== 16'h0000 || estado_dbg !== 3'(ENT_A)) begin
      failures++; $display("FAIL reset_mid got disp=%h conv=%h state=%0d exp 0000 0000 0", display_bcd, conv_bcd, estado_dbg);
    end
    press(4'd4);
    checks++;
    if (display_bcd !== 16'h0004) begin failures++; $display("FAIL reset_mid_cnt got=%h exp=0004", display_bcd); end
  endtask

  task automatic test_codigos_ignorados();
    press(TECLA_BORRAR);
    press(4'd1);
    press(4'd2);
    press(4'hD); press(4'hE); press(4'hF);
    checks++;
    if (display_bcd !== 16'h0012 || estado_dbg !== 3'(ENT_A)) begin
      failures++; $display("FAIL ign_ent_a got disp=%h state=%0d exp disp=0012 state=0", display_bcd, estado_dbg);
    end
    press(TECLA_SUMA);
    press(4'd3);
    press(4'hD); press(TECLA_SUMA); press(4'hE); press(4'hF);
    checks++;
    if (display_bcd !== 16'h0003 || estado_dbg !== 3'(ENT_B)) begin
      failures++; $display("FAIL ign_ent_b got disp=%h state=%0d exp disp=0003 state=1", display_bcd, estado_dbg);
    end
    press(TECLA_IGUAL);
    press(4'hD);
    press(4'hE);
    press(4'hF);
    checks++;
    if (estado_dbg !== 3'(RESULT) || resultado !== 15'd15 || resultado_valido !== 1'b1) begin
      failures++; $display("FAIL ign_conv got state=%0d res=%0d valid=%b exp state=5 res=15 valid=1", estado_dbg, resultado, resultado_valido);
    end
    press(4'hD); press(TECLA_SUMA); press(4'hE); press(TECLA_IGUAL); press(4'hF);
    checks++;
    if (estado_dbg !== 3'(RESULT) || resultado !== 15'd15 || resultado_valido !== 1'b1 || display_bcd !== 16'h0003) begin
      failures++; $display("FAIL ign_result got state=%0d res=%0d valid=%b disp=%h exp state=5 res=15 valid=1 disp=0003", estado_dbg, resultado, resultado_valido, display_bcd);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    tecla_valida = 1'b0;
    tecla        = 4'h0;
    @(negedge clk);
    test_reset();
    test_suma_basica();
    test_maximo();
    test_b_cero();
    test_ocupado_ignora();
    test_resultado_digito();
    test_borrar_suma();
    test_reset_mid();
    test_codigos_ignorados();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
